pipe_cla_alu_adder: RTL

- Parametrised, 2-stage pipelined carry-lookahead adder/subtractor/comparator for the EX stage's add/sub/slt/sltu datapath.
- Successor to the single-bit full adder cell: generalised to WIDTH bits with BLOCK-bit lookahead groups, plus op modes and a valid/ready pipeline.
- Supports stall (backpressure) and flush (exception/branch kill).
- Exposes group generate/propagate for reuse by the downstream comparator/branch logic.

---
 rtl/pipe_cla_alu_adder_pkg.sv | 16 +
 rtl/pipe_cla_alu_adder_cla_group.sv | 37 +++
 rtl/pipe_cla_alu_adder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_cla_alu_adder_pkg.sv
// Shared op encodings and sizing helper for the pipelined carry-lookahead
// adder/subtractor/comparator.
package alu_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLT  = 2'b10,
    OP_SLTU = 2'b11
  } alu_op_e;

  function automatic int ngrp(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/pipe_cla_alu_adder_cla_group.sv
// One BLOCK-bit lookahead group: bit sums for a given carry-in plus the
// group generate/propagate and carry-out.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             g_grp,
  output logic             p_grp,
  output logic             cout
);

  logic [BLOCK-1:0] g_s;
  logic [BLOCK-1:0] p_s;
  logic             carry_s;

  assign g_s = a & b;
  assign p_s = a | b;

  // Bit carries inside the group; G/P fold from LSB towards MSB
  always_comb begin
    carry_s = cin;
    g_grp   = 1'b0;
    p_grp   = 1'b1;
    sum     = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = g_s[i] | (p_s[i] & carry_s);
      g_grp   = g_s[i] | (p_s[i] & g_grp);
      p_grp   = p_grp & p_s[i];
    end
    cout = carry_s;
  end

endmodule

// File: rtl/pipe_cla_alu_adder.sv
// Two-stage pipelined CLA add/sub/slt/sltu: stage 1 conditions operands and
// forms group G/P, stage 2 resolves group carries and forms the result.
module pipe_cla_alu_adder
  import alu_adder_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int BLOCK = 4,
  localparam int NGRP  = ngrp(WIDTH, BLOCK)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [NGRP-1:0]  out_grp_g,
  output logic [NGRP-1:0]  out_grp_p
);

  logic             s2_adv_s;
  logic             accept_s;
  logic [WIDTH-1:0] b_cond_s;
  logic             cin_s;
  logic [NGRP-1:0]  s1_grp_g_s;
  logic [NGRP-1:0]  s1_grp_p_s;
  logic [WIDTH-1:0] s1_sum_unused;
  logic [NGRP-1:0]  s1_cout_unused;
  logic [NGRP:0]    grp_c_s;
  logic             chain_s;
  logic [WIDTH-1:0] sum_s;
  logic [NGRP-1:0]  s2_g_unused;
  logic [NGRP-1:0]  s2_p_unused;
  logic [NGRP-1:0]  s2_cout_unused;
  logic             ovf_raw_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic [NGRP-1:0]  s1_g_q, s1_g_d;
  logic [NGRP-1:0]  s1_p_q, s1_p_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_cout_q, s2_cout_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic [NGRP-1:0]  s2_g_q, s2_g_d;
  logic [NGRP-1:0]  s2_p_q, s2_p_d;

  assign s2_adv_s = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv_s;
  assign accept_s = in_valid & in_ready & ~flush;

  // Everything except ADD is a - b computed as a + ~b + 1
  always_comb begin
    if (in_op == OP_ADD) begin
      b_cond_s = in_b;
      cin_s    = 1'b0;
    end else begin
      b_cond_s = ~in_b;
      cin_s    = 1'b1;
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
    cla_group #(.BLOCK(BLOCK)) u_gp (
      .a     (in_a[k*BLOCK +: BLOCK]),
      .b     (b_cond_s[k*BLOCK +: BLOCK]),
      .cin   (1'b0),
      .sum   (s1_sum_unused[k*BLOCK +: BLOCK]),
      .g_grp (s1_grp_g_s[k]),
      .p_grp (s1_grp_p_s[k]),
      .cout  (s1_cout_unused[k])
    );
  end

  // Group carry lookahead over the registered G/P
  always_comb begin
    chain_s    = s1_cin_q;
    grp_c_s    = '0;
    grp_c_s[0] = chain_s;
    for (int k = 0; k < NGRP; k++) begin
      chain_s      = s1_g_q[k] | (s1_p_q[k] & chain_s);
      grp_c_s[k+1] = chain_s;
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
    cla_group #(.BLOCK(BLOCK)) u_sum (
      .a     (s1_a_q[k*BLOCK +: BLOCK]),
      .b     (s1_b_q[k*BLOCK +: BLOCK]),
      .cin   (grp_c_s[k]),
      .sum   (sum_s[k*BLOCK +: BLOCK]),
      .g_grp (s2_g_unused[k]),
      .p_grp (s2_p_unused[k]),
      .cout  (s2_cout_unused[k])
    );
  end

  // Result select; compares turn the difference sign or borrow into one bit
  always_comb begin
    ovf_raw_s = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) & (sum_s[WIDTH-1] != s1_a_q[WIDTH-1]);
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        res_s = sum_s;
        ovf_s = ovf_raw_s;
      end
      OP_SLT: begin
        res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_raw_s};
        ovf_s = 1'b0;
      end
      OP_SLTU: begin
        res_s = {{(WIDTH-1){1'b0}}, ~grp_c_s[NGRP]};
        ovf_s = 1'b0;
      end
      default: begin
        res_s = '0;
        ovf_s = 1'b0;
      end
    endcase
  end

  // Stage 1 next state: flush wins, otherwise refill whenever there is room
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_op_d    = s1_op_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      s1_a_d   = in_a;
      s1_b_d   = b_cond_s;
      s1_cin_d = cin_s;
      s1_op_d  = alu_op_e'(in_op);
      s1_g_d   = s1_grp_g_s;
      s1_p_d   = s1_grp_p_s;
    end else begin
      s1_op_d  = s1_op_q;
    end
  end

  // Stage 2 next state: output holds while stalled
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_cout_d   = s2_cout_q;
    s2_ovf_d    = s2_ovf_q;
    s2_g_d      = s2_g_q;
    s2_p_d      = s2_p_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = res_s;
        s2_cout_d   = grp_c_s[NGRP];
        s2_ovf_d    = ovf_s;
        s2_g_d      = s1_g_q;
        s2_p_d      = s1_p_q;
      end else begin
        s2_result_d = s2_result_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_g_q      <= '0;
      s1_p_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_cout_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_g_q      <= '0;
      s2_p_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_op_q     <= s1_op_d;
      s1_g_q      <= s1_g_d;
      s1_p_q      <= s1_p_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_cout_q   <= s2_cout_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_g_q      <= s2_g_d;
      s2_p_q      <= s2_p_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_cout   = s2_cout_q;
  assign out_ovf    = s2_ovf_q;
  assign out_grp_g  = s2_g_q;
  assign out_grp_p  = s2_p_q;

endmodule
